// File: rtl/us_mac_rx_dispatch.sv
// MAC RX frame dispatcher: filters on destination MAC, steers frames
// to the IP or ARP stream by EtherType, and keeps per-class counters.
module us_mac_rx_dispatch #(
  parameter int          COUNT_W  = 32,
  parameter logic [15:0] IP_TYPE  = 16'h0800,
  parameter logic [15:0] ARP_TYPE = 16'h0806
) (
  input  logic               rx_axis_aclk,
  input  logic               rx_axis_aresetn,
  input  logic [63:0]        rx_mac_axis_tdata,
  input  logic [7:0]         rx_mac_axis_tkeep,
  input  logic               rx_mac_axis_tvalid,
  input  logic               rx_mac_axis_tuser,
  input  logic               rx_mac_axis_tlast,
  input  logic [47:0]        local_mac_addr,
  input  logic               promisc_en,
  output logic [63:0]        ip_axis_tdata,
  output logic [7:0]         ip_axis_tkeep,
  output logic               ip_axis_tvalid,
  output logic               ip_axis_tuser,
  output logic               ip_axis_tlast,
  output logic [63:0]        arp_axis_tdata,
  output logic [7:0]         arp_axis_tkeep,
  output logic               arp_axis_tvalid,
  output logic               arp_axis_tuser,
  output logic               arp_axis_tlast,
  output logic [COUNT_W-1:0] frame_ip_cnt,
  output logic [COUNT_W-1:0] frame_arp_cnt,
  output logic [COUNT_W-1:0] frame_drop_cnt,
  output logic [COUNT_W-1:0] frame_err_cnt,
  output logic [15:0]        last_type
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FWD   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  logic [2:0]         r_state;
  logic [63:0]        r_hold_data;
  logic [7:0]         r_hold_keep;
  logic               r_hold_user;
  logic               r_sel_arp;
  logic [63:0]        r_out_data;
  logic [7:0]         r_out_keep;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_out_user;
  logic [COUNT_W-1:0] r_ip_cnt;
  logic [COUNT_W-1:0] r_arp_cnt;
  logic [COUNT_W-1:0] r_drop_cnt;
  logic [COUNT_W-1:0] r_err_cnt;
  logic [15:0]        r_last_type;

  logic [47:0] w_dst;
  logic [15:0] w_type;
  logic        w_match;
  logic        w_is_ip;
  logic        w_is_arp;
  logic        w_fwd;

  // Beat 0 sits in hold while beat 1 carries the EtherType.
  assign w_dst = {r_hold_data[7:0],   r_hold_data[15:8],
                  r_hold_data[23:16], r_hold_data[31:24],
                  r_hold_data[39:32], r_hold_data[47:40]};
  assign w_type = {rx_mac_axis_tdata[39:32],
                   rx_mac_axis_tdata[47:40]};
  assign w_match = (w_dst == local_mac_addr)
                 | (w_dst == 48'hFFFF_FFFF_FFFF)
                 | promisc_en;
  assign w_is_ip  = w_match & (w_type == IP_TYPE);
  assign w_is_arp = w_match & (w_type == ARP_TYPE);
  assign w_fwd    = w_is_ip | w_is_arp;

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      r_state     <= S_IDLE;
      r_hold_data <= '0;
      r_hold_keep <= '0;
      r_hold_user <= 1'b0;
      r_sel_arp   <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_user  <= 1'b0;
      r_ip_cnt    <= '0;
      r_arp_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_err_cnt   <= '0;
      r_last_type <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_user  <= 1'b0;
      unique case (r_state)
        S_IDLE, S_FLUSH: begin
          if (r_state == S_FLUSH) begin
            r_out_data  <= r_hold_data;
            r_out_keep  <= r_hold_keep;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_out_user  <= r_hold_user;
            if (r_sel_arp) r_arp_cnt <= r_arp_cnt + 1'b1;
            else           r_ip_cnt  <= r_ip_cnt + 1'b1;
            if (r_hold_user) r_err_cnt <= r_err_cnt + 1'b1;
          end
          if (rx_mac_axis_tvalid) begin
            r_hold_data <= rx_mac_axis_tdata;
            r_hold_keep <= rx_mac_axis_tkeep;
            r_hold_user <= rx_mac_axis_tuser;
            if (rx_mac_axis_tlast) begin
              r_drop_cnt <= r_drop_cnt + 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_HDR;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HDR: begin
          if (rx_mac_axis_tvalid) begin
            r_last_type <= w_type;
            if (w_fwd) begin
              r_out_data  <= r_hold_data;
              r_out_keep  <= r_hold_keep;
              r_out_valid <= 1'b1;
              r_sel_arp   <= w_is_arp;
              r_hold_data <= rx_mac_axis_tdata;
              r_hold_keep <= rx_mac_axis_tkeep;
              r_hold_user <= rx_mac_axis_tuser;
              r_state <= rx_mac_axis_tlast ? S_FLUSH : S_FWD;
            end else begin
              r_drop_cnt <= r_drop_cnt + 1'b1;
              r_state <= rx_mac_axis_tlast ? S_IDLE : S_DROP;
            end
          end
        end
        S_FWD: begin
          if (rx_mac_axis_tvalid) begin
            r_out_data  <= r_hold_data;
            r_out_keep  <= r_hold_keep;
            r_out_valid <= 1'b1;
            r_hold_data <= rx_mac_axis_tdata;
            r_hold_keep <= rx_mac_axis_tkeep;
            r_hold_user <= rx_mac_axis_tuser;
            if (rx_mac_axis_tlast) r_state <= S_FLUSH;
          end
        end
        S_DROP: begin
          if (rx_mac_axis_tvalid && rx_mac_axis_tlast)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data is shared; only the selected port sees valid/last/user.
  assign ip_axis_tdata   = r_out_data;
  assign ip_axis_tkeep   = r_out_keep;
  assign ip_axis_tvalid  = r_out_valid & ~r_sel_arp;
  assign ip_axis_tlast   = r_out_last  & ~r_sel_arp;
  assign ip_axis_tuser   = r_out_user  & ~r_sel_arp;
  assign arp_axis_tdata  = r_out_data;
  assign arp_axis_tkeep  = r_out_keep;
  assign arp_axis_tvalid = r_out_valid & r_sel_arp;
  assign arp_axis_tlast  = r_out_last  & r_sel_arp;
  assign arp_axis_tuser  = r_out_user  & r_sel_arp;

  assign frame_ip_cnt   = r_ip_cnt;
  assign frame_arp_cnt  = r_arp_cnt;
  assign frame_drop_cnt = r_drop_cnt;
  assign frame_err_cnt  = r_err_cnt;
  assign last_type      = r_last_type;

endmodule

// File: tb/tb_us_mac_rx_dispatch.sv
// Directed bench for us_mac_rx_dispatch (narrow counters so the
// wrap case is reachable with a handful of runt frames).
module tb_us_mac_rx_dispatch;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   rx_tdata = '0;
  logic [7:0]    rx_tkeep = '0;
  logic          rx_tvalid = 1'b0;
  logic          rx_tuser = 1'b0;
  logic          rx_tlast = 1'b0;
  logic [47:0]   local_mac = 48'h02_00_00_00_00_01;
  logic          promisc = 1'b0;
  logic [63:0]   ip_tdata, arp_tdata;
  logic [7:0]    ip_tkeep, arp_tkeep;
  logic          ip_tvalid, ip_tuser, ip_tlast;
  logic          arp_tvalid, arp_tuser, arp_tlast;
  logic [CW-1:0] ip_cnt, arp_cnt, drop_cnt, err_cnt;
  logic [15:0]   last_type;

  us_mac_rx_dispatch #(.COUNT_W(CW)) dut (
    .rx_axis_aclk      (clk),
    .rx_axis_aresetn   (rst_n),
    .rx_mac_axis_tdata (rx_tdata),
    .rx_mac_axis_tkeep (rx_tkeep),
    .rx_mac_axis_tvalid(rx_tvalid),
    .rx_mac_axis_tuser (rx_tuser),
    .rx_mac_axis_tlast (rx_tlast),
    .local_mac_addr    (local_mac),
    .promisc_en        (promisc),
    .ip_axis_tdata     (ip_tdata),
    .ip_axis_tkeep     (ip_tkeep),
    .ip_axis_tvalid    (ip_tvalid),
    .ip_axis_tuser     (ip_tuser),
    .ip_axis_tlast     (ip_tlast),
    .arp_axis_tdata    (arp_tdata),
    .arp_axis_tkeep    (arp_tkeep),
    .arp_axis_tvalid   (arp_tvalid),
    .arp_axis_tuser    (arp_tuser),
    .arp_axis_tlast    (arp_tlast),
    .frame_ip_cnt      (ip_cnt),
    .frame_arp_cnt     (arp_cnt),
    .frame_drop_cnt    (drop_cnt),
    .frame_err_cnt     (err_cnt),
    .last_type         (last_type)
  );

  always #5 clk = ~clk;

  typedef logic [73:0] beat_t;
  beat_t ip_q[$], arp_q[$], exp_ip[$], exp_arp[$];
  int n_pass = 0;
  int n_total = 0;
  int excl_err = 0;

  always @(negedge clk) begin
    if (ip_tvalid)  ip_q.push_back({ip_tdata, ip_tkeep, ip_tlast, ip_tuser});
    if (arp_tvalid) arp_q.push_back({arp_tdata, arp_tkeep, arp_tlast, arp_tuser});
    if (ip_tvalid && arp_tvalid) excl_err++;
    if (!ip_tvalid && (ip_tlast || ip_tuser)) excl_err++;
    if (!arp_tvalid && (arp_tlast || arp_tuser)) excl_err++;
  end

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mk0(input logic [47:0] dst);
    return {16'h5A5A, dst[7:0], dst[15:8], dst[23:16],
            dst[31:24], dst[39:32], dst[47:40]};
  endfunction

  function automatic logic [63:0] mk1(input logic [15:0] typ);
    return {16'h1111, typ[7:0], typ[15:8], 32'h2222_3333};
  endfunction

  task automatic idle(input int n);
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
    rx_tdata  = '1;
    repeat (n) @(negedge clk);
  endtask

  // dest: 0 dropped, 1 IP, 2 ARP
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ,
                            input int n, input logic [7:0] lkeep,
                            input logic usr, input int dest,
                            input int gap_at, input int gap_len,
                            input logic [7:0] fid);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l, u;
    for (int i = 0; i < n; i++) begin
      if (i == 0)      d = mk0(dst);
      else if (i == 1) d = mk1(typ);
      else             d = {fid, 8'(i), 48'h0123_4567_89AB};
      l = (i == n - 1);
      k = l ? lkeep : 8'hFF;
      u = l ? usr : 1'b0;
      rx_tdata = d; rx_tkeep = k; rx_tlast = l; rx_tuser = u;
      rx_tvalid = 1'b1;
      @(negedge clk);
      if (dest == 1) exp_ip.push_back({d, k, l, u});
      if (dest == 2) exp_arp.push_back({d, k, l, u});
      if (i == gap_at) idle(gap_len);
    end
  endtask

  task automatic cmp_ports(input string tag);
    chk({tag, " ip_len"}, 80'(ip_q.size()), 80'(exp_ip.size()));
    chk({tag, " arp_len"}, 80'(arp_q.size()), 80'(exp_arp.size()));
    for (int i = 0; i < ip_q.size() && i < exp_ip.size(); i++)
      chk($sformatf("%s ip_beat%0d", tag, i), 80'(ip_q[i]), 80'(exp_ip[i]));
    for (int i = 0; i < arp_q.size() && i < exp_arp.size(); i++)
      chk($sformatf("%s arp_beat%0d", tag, i), 80'(arp_q[i]), 80'(exp_arp[i]));
    ip_q.delete(); arp_q.delete(); exp_ip.delete(); exp_arp.delete();
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst ip_tvalid", 80'(ip_tvalid), 80'(0));
    chk("rst arp_tvalid", 80'(arp_tvalid), 80'(0));
    chk("rst cnts", 80'({ip_cnt, arp_cnt, drop_cnt, err_cnt}), 80'(0));
    chk("rst last_type", 80'(last_type), 80'(0));
    rst_n = 1'b1;
    idle(2);

    // local unicast IP, 4 beats, short last beat
    send_frame(48'h02_00_00_00_00_01, 16'h0800, 4, 8'h0F, 1'b0, 1, -1, 0, 8'h01);
    idle(3);
    cmp_ports("t1");
    chk("t1 ip_cnt", 80'(ip_cnt), 80'(1));
    chk("t1 last_type", 80'(last_type), 80'(16'h0800));

    // broadcast ARP then back-to-back IP
    send_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 8, 8'h3F, 1'b0, 2, -1, 0, 8'h02);
    send_frame(48'h02_00_00_00_00_01, 16'h0800, 3, 8'hFF, 1'b0, 1, -1, 0, 8'h03);
    idle(3);
    cmp_ports("t2");
    chk("t2 arp_cnt", 80'(arp_cnt), 80'(1));
    chk("t2 ip_cnt", 80'(ip_cnt), 80'(2));

    // destination filter, then promiscuous
    send_frame(48'h02_00_00_00_00_99, 16'h0800, 3, 8'hFF, 1'b0, 0, -1, 0, 8'h04);
    idle(3);
    cmp_ports("t3a");
    chk("t3a drop_cnt", 80'(drop_cnt), 80'(1));
    promisc = 1'b1;
    send_frame(48'h02_00_00_00_00_99, 16'h0800, 3, 8'hFF, 1'b0, 1, -1, 0, 8'h05);
    idle(3);
    promisc = 1'b0;
    cmp_ports("t3b");
    chk("t3b ip_cnt", 80'(ip_cnt), 80'(3));

    // unknown type and 1-beat runt
    send_frame(48'h02_00_00_00_00_01, 16'h86DD, 4, 8'hFF, 1'b0, 0, -1, 0, 8'h06);
    send_frame(48'h02_00_00_00_00_01, 16'h0800, 1, 8'hFF, 1'b0, 0, -1, 0, 8'h07);
    idle(3);
    cmp_ports("t4");
    chk("t4 drop_cnt", 80'(drop_cnt), 80'(3));
    chk("t4 last_type", 80'(last_type), 80'(16'h86DD));

    // input gap mid-frame plus error on last beat
    send_frame(48'h02_00_00_00_00_01, 16'h0800, 5, 8'h01, 1'b1, 1, 2, 3, 8'h08);
    idle(3);
    cmp_ports("t5");
    chk("t5 err_cnt", 80'(err_cnt), 80'(1));
    chk("t5 ip_cnt", 80'(ip_cnt), 80'(4));

    // drop counter wrap: 3 + 12 = 15, then one more
    for (int i = 0; i < 12; i++)
      send_frame(48'h02_00_00_00_00_01, 16'h0800, 1, 8'hFF, 1'b0, 0, -1, 0, 8'h09);
    idle(1);
    chk("wrap all_ones", 80'(drop_cnt), 80'(4'hF));
    send_frame(48'h02_00_00_00_00_01, 16'h0800, 1, 8'hFF, 1'b0, 0, -1, 0, 8'h0A);
    idle(1);
    chk("wrap zero", 80'(drop_cnt), 80'(0));

    // async reset while forwarding
    rx_tvalid = 1'b1; rx_tlast = 1'b0; rx_tuser = 1'b0; rx_tkeep = 8'hFF;
    rx_tdata = mk0(48'h02_00_00_00_00_01);
    @(negedge clk);
    rx_tdata = mk1(16'h0800);
    @(negedge clk);
    rx_tdata = 64'hDEAD_BEEF_0000_0002;
    chk("t6 pre_rst ip_tvalid", 80'(ip_tvalid), 80'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t6 rst ip_tvalid", 80'(ip_tvalid), 80'(0));
    chk("t6 rst cnts", 80'({ip_cnt, arp_cnt, drop_cnt, err_cnt}), 80'(0));
    rx_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ip_q.delete(); arp_q.delete(); exp_ip.delete(); exp_arp.delete();
    idle(1);
    send_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 3, 8'h07, 1'b0, 2, -1, 0, 8'h0B);
    idle(3);
    cmp_ports("t6");
    chk("t6 arp_cnt", 80'(arp_cnt), 80'(1));
    chk("t6 ip_cnt", 80'(ip_cnt), 80'(0));
    chk("t6 last_type", 80'(last_type), 80'(16'h0806));

    chk("port exclusivity", 80'(excl_err), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/us_mac_rx_dispatch.md
Name: us_mac_rx_dispatch

Overview:
- Receive-side frame controller between the 10G MAC RX AXI-Stream and the protocol engines.
- Parses the destination MAC and EtherType from the first two beats of each frame and applies a destination-address filter.
- Steers the whole frame, header intact, to the IP port or the ARP port, or drops it. Keeps per-class frame counters.
- No backpressure anywhere, matching the MAC. Operates as a one-valid-beat delay line with a per-frame routing decision.

Parameters:
- COUNT_W, 32, width of every statistics counter; counters wrap modulo 2^COUNT_W.
- IP_TYPE, 16'h0800, EtherType routed to the IP port.
- ARP_TYPE, 16'h0806, EtherType routed to the ARP port.

Ports:
- rx_axis_aclk  in  1  clock.
- rx_axis_aresetn  in  1  reset, asynchronous, active-low.
- rx_mac_axis_tdata  in  64  MAC RX data; byte n on lanes [8n+7:8n].
- rx_mac_axis_tkeep  in  8  byte enables.
- rx_mac_axis_tvalid  in  1  beat valid.
- rx_mac_axis_tuser  in  1  frame error, meaningful on the tlast beat.
- rx_mac_axis_tlast  in  1  last beat of frame.
- local_mac_addr  in  48  station MAC; [47:40] is the first byte on the wire.
- promisc_en  in  1  1 = skip the destination-MAC filter; sampled at each decision.
- ip_axis_tdata/tkeep/tvalid/tuser/tlast  out  64/8/1/1/1  IP frame stream.
- arp_axis_tdata/tkeep/tvalid/tuser/tlast  out  64/8/1/1/1  ARP frame stream.
- frame_ip_cnt  out  COUNT_W  IP frames forwarded.
- frame_arp_cnt  out  COUNT_W  ARP frames forwarded.
- frame_drop_cnt  out  COUNT_W  frames dropped (filter, type, or runt).
- frame_err_cnt  out  COUNT_W  forwarded frames ending with tuser=1.
- last_type  out  16  EtherType of the most recent decided frame.

Behaviour:
- Reset: all outputs 0. Hold registers, counters and last_type are cleared; state = IDLE.
- Reset mid-frame: state is forced to IDLE immediately. The next valid beat is treated as beat 0 of a new frame.
- Field extraction:
  - dst MAC = {b0,b1,b2,b3,b4,b5} of beat 0, i.e. {tdata[7:0], tdata[15:8], ..., tdata[47:40]}.
  - EtherType = {beat1 tdata[39:32], beat1 tdata[47:40]}.
- Address match: dst == local_mac_addr, or dst == 48'hFFFF_FFFF_FFFF, or promisc_en=1.
- Decision, made combinationally on the cycle beat 1 is accepted:
  - IP if match and type == IP_TYPE.
  - ARP if match and type == ARP_TYPE.
  - Otherwise DROP.
- last_type updates on every decision, including drops.
- States:
  - IDLE: on a valid beat, store it in hold. If tlast, it is a runt: increment frame_drop_cnt and stay in IDLE. Otherwise go to HDR.
  - HDR: on a valid beat, decide.
    - If forwarding: the next cycle emits hold (beat 0) on the selected port with tlast=0; the current beat is stored in hold; go to FWD.
    - If dropping: increment frame_drop_cnt; go to IDLE if tlast, else DROP.
  - FWD: on each valid beat, the next cycle emits hold; the new beat is stored in hold.
    - When the input tlast beat is accepted, go to FLUSH.
    - That accepted beat is marked last in hold.
  - FLUSH: the held last beat is emitted the next cycle with tlast=1 and tuser=held tuser.
    - Increment the class counter, and frame_err_cnt if tuser=1.
    - A valid input beat in this same cycle is processed exactly as in IDLE, so back-to-back frames are not lost.
- Output timing: the output is a register. Latency is one valid input beat, plus one cycle of register delay. Input gaps (tvalid=0 mid-frame) produce output gaps; there is no timeout.
- Port exclusivity: only the selected port asserts tvalid, and ip_axis_tvalid and arp_axis_tvalid are never high together. The non-selected port's data is don't-care, but its tvalid/tlast/tuser are held at 0.
- tuser is 0 on all non-last output beats. tkeep passes through unchanged.
- Counter wrap: all-ones + 1 → 0, with no saturation.

Test Plan:
- Local unicast IP: dst=local_mac_addr=02:00:00:00:00:01, type 0x0800, 4 beats, last tkeep=8'h0F → 4 beats on ip_axis with identical data/tkeep, tlast on beat 4 only; arp_axis_tvalid stays 0; frame_ip_cnt=1; last_type=16'h0800.
- Broadcast ARP, 8 beats, followed by an IP frame whose beat 0 arrives in the cycle after the ARP tlast → ARP frame fully on arp_axis, IP frame fully on ip_axis, no beats lost; frame_arp_cnt=1, frame_ip_cnt=1.
- Filter: dst=02:00:00:00:00:99 IP frame with promisc_en=0 → no output, frame_drop_cnt=1. Same frame with promisc_en=1 → forwarded to IP.
- Unknown type 0x86DD, and a 1-beat runt with tlast on beat 0 → nothing emitted, frame_drop_cnt=2, last_type=16'h86DD.
- Error and gaps: IP frame with tvalid deasserted for 3 cycles mid-frame and tuser=1 on last → output beat order preserved, tuser=1 only on the ip_axis tlast beat, frame_err_cnt=1; preload counter to all-ones and it wraps to 0.
- Reset asserted during FWD → all tvalid drop to 0 asynchronously, counters read 0, and a subsequent clean ARP frame is routed correctly.
